// File: rtl/bp_be_stream_prefetcher.sv
// bp_be_stream_prefetcher: multi-stream strided load prefetcher, one block-aligned request per block crossing
module bp_be_stream_prefetcher #(
  parameter int vaddr_width_p        = 39,
  parameter int streams_p            = 4,
  parameter int loop_range_p         = 8,
  parameter int stride_width_p       = 8,
  parameter int block_offset_width_p = 6,
  parameter int replace_p            = 1
) (
  input  logic                      clk_i,
  input  logic                      reset_n_i,
  input  logic                      flush_i,
  input  logic                      v_i,
  output logic                      ready_and_o,
  input  logic [vaddr_width_p-1:0]  pc_i,
  input  logic [vaddr_width_p-1:0]  eff_addr_i,
  input  logic [stride_width_p-1:0] stride_i,
  input  logic [loop_range_p-1:0]   loop_counter_i,
  output logic                      v_o,
  input  logic                      yumi_i,
  output logic [vaddr_width_p-1:0]  pf_vaddr_o,
  output logic [vaddr_width_p-1:0]  pf_pc_o
);
  localparam int idx_w = $clog2(streams_p);
  localparam int bo = block_offset_width_p;
  localparam logic rep_en = replace_p != 0;
  typedef enum logic [1:0] {e_idle, e_advance, e_send} state_e;
  state_e st_r [streams_p];
  state_e st_n [streams_p];
  logic [vaddr_width_p-1:0] pc_r [streams_p];
  logic [vaddr_width_p-1:0] pc_n [streams_p];
  logic [vaddr_width_p-1:0] addr_r [streams_p];
  logic [vaddr_width_p-1:0] addr_n [streams_p];
  logic [vaddr_width_p-1:0] stride_r [streams_p];
  logic [vaddr_width_p-1:0] stride_n [streams_p];
  logic [loop_range_p-1:0] cnt_r [streams_p];
  logic [loop_range_p-1:0] cnt_n [streams_p];
  logic [idx_w-1:0] vic_r, vic_n, last_r, last_n, gnt_r, gnt_n, hit_idx, idle_idx, tgt, pick;
  logic [streams_p-1:0] hit, idle, send_n;
  logic gnt_v_r, gnt_v_n, found, any_hit, any_idle, load, fire, hold;
  logic [vaddr_width_p-1:0] stride_ext;
  assign fire = gnt_v_r & yumi_i;
  assign hold = gnt_v_r & ~yumi_i;
  assign stride_ext = {{(vaddr_width_p-stride_width_p){stride_i[stride_width_p-1]}}, stride_i};
  always_comb begin
    hit = '0;
    idle = '0;
    hit_idx = '0;
    idle_idx = '0;
    for (int i = streams_p-1; i >= 0; i--) begin
      hit[i] = (st_r[i] != e_idle) && (pc_r[i] == pc_i);
      idle[i] = st_r[i] == e_idle;
      if (hit[i]) hit_idx = idx_w'(i);
      if (idle[i]) idle_idx = idx_w'(i);
    end
  end
  assign any_hit = |hit;
  assign any_idle = |idle;
  assign tgt = any_hit ? hit_idx : any_idle ? idle_idx : vic_r;
  // a victim that is the held grant would corrupt the stable output, so it is refused too
  assign ready_and_o = reset_n_i & ~flush_i & ~(gnt_v_r & (pc_i == pc_r[gnt_r]))
                     & (any_hit | any_idle | (rep_en & ~(gnt_v_r & (vic_r == gnt_r))));
  assign load = v_i & ready_and_o & (loop_counter_i != '0);
  assign vic_n = vic_r + idx_w'(load & ~any_hit & ~any_idle);
  always_comb begin
    st_n = st_r;
    pc_n = pc_r;
    addr_n = addr_r;
    stride_n = stride_r;
    cnt_n = cnt_r;
    for (int i = 0; i < streams_p; i++) begin
      if (flush_i) st_n[i] = e_idle;
      else if (load && tgt == idx_w'(i)) begin
        pc_n[i] = pc_i;
        addr_n[i] = eff_addr_i;
        stride_n[i] = stride_ext;
        cnt_n[i] = loop_counter_i;
        st_n[i] = e_advance;
      end else if (st_r[i] == e_advance) begin
        addr_n[i] = addr_r[i] + stride_r[i];
        cnt_n[i] = cnt_r[i] - 1'b1;
        st_n[i] = (addr_n[i][vaddr_width_p-1:bo] != addr_r[i][vaddr_width_p-1:bo]) ? e_send
                : (cnt_n[i] == '0) ? e_idle : e_advance;
      end else if (st_r[i] == e_send && fire && gnt_r == idx_w'(i))
        st_n[i] = (cnt_r[i] == '0) ? e_idle : e_advance;
    end
  end
  for (genvar g = 0; g < streams_p; g++) begin : g_send
    assign send_n[g] = st_n[g] == e_send;
  end
  assign last_n = fire ? gnt_r : last_r;
  // arbitrate on next-cycle slot state so a fresh SEND is visible on v_o the same cycle
  always_comb begin
    found = 1'b0;
    pick = gnt_r;
    for (int k = 1; k <= streams_p; k++)
      if (!found && send_n[last_n + idx_w'(k)]) begin
        found = 1'b1;
        pick = last_n + idx_w'(k);
      end
  end
  assign gnt_v_n = ~flush_i & (hold | found);
  assign gnt_n = hold ? gnt_r : pick;
  always_ff @(posedge clk_i or negedge reset_n_i)
    if (!reset_n_i) begin
      for (int i = 0; i < streams_p; i++) st_r[i] <= e_idle;
      vic_r <= '0;
      last_r <= '0;
      gnt_r <= '0;
      gnt_v_r <= 1'b0;
    end else begin
      st_r <= st_n;
      vic_r <= vic_n;
      last_r <= last_n;
      gnt_r <= gnt_n;
      gnt_v_r <= gnt_v_n;
    end
  always_ff @(posedge clk_i) begin
    pc_r <= pc_n;
    addr_r <= addr_n;
    stride_r <= stride_n;
    cnt_r <= cnt_n;
  end
  assign v_o = gnt_v_r;
  assign pf_vaddr_o = {addr_r[gnt_r][vaddr_width_p-1:bo], {bo{1'b0}}};
  assign pf_pc_o = pc_r[gnt_r];
endmodule

// File: doc/bp_be_stream_prefetcher.md
Name: bp_be_stream_prefetcher

Overview:
- Multi-stream successor to the single-stream striding-load prefetch generator in the BE checker.
- Tracks up to streams_p independent strided load streams, one per load PC.
- Each stream walks its stride and emits one block-aligned prefetch address per cache-block crossing.
- Prefetch requests from all active streams are arbitrated onto a single valid/yumi output, which feeds downstream dispatch-packet formation for prefetch.r.

Parameters:
- vaddr_width_p, 39, virtual address width.
- streams_p, 4, number of stream slots (power of 2, ≥2).
- loop_range_p, 8, width of the remaining-iteration counter.
- stride_width_p, 8, width of the stride; two's-complement signed.
- block_offset_width_p, 6, log2 of cache block size in bytes.
- replace_p, 1, behaviour when all slots are busy: 1 = round-robin victim replacement; 0 = backpressure.

Ports:
- clk_i  in  1  clock.
- reset_n_i  in  1  asynchronous active-low reset.
- flush_i  in  1  synchronous clear of all streams.
- v_i  in  1  training request valid.
- ready_and_o  out  1  training request accepted when high together with v_i.
- pc_i  in  vaddr_width_p  load PC; serves as the stream tag.
- eff_addr_i  in  vaddr_width_p  effective address of the triggering load.
- stride_i  in  stride_width_p  signed stride in bytes.
- loop_counter_i  in  loop_range_p  remaining iterations.
- v_o  out  1  prefetch request valid.
- yumi_i  in  1  consumer takes the request; legal only while v_o is high.
- pf_vaddr_o  out  vaddr_width_p  block-aligned prefetch address (low block_offset_width_p bits zero).
- pf_pc_o  out  vaddr_width_p  PC of the originating stream.

Behaviour:
- Reset: async assert clears all slots to IDLE and zeroes the victim pointer and arbiter pointer. While reset is asserted, v_o = 0 and ready_and_o = 0. Reset deassertion is synchronised externally.
- Per-slot state: pc, addr, blk = addr[vaddr-1:block_offset_width_p], stride sign-extended to vaddr_width_p, count, fsm ∈ {IDLE, ADVANCE, SEND}.
- Training handshake: a request is accepted in cycle T when v_i & ready_and_o.
  - Target selection: a non-IDLE slot whose pc matches pc_i is retrained in place. Otherwise the lowest-index IDLE slot is used. Otherwise, if replace_p = 1, the slot at the victim pointer is used and the pointer increments modulo streams_p.
  - The target loads addr = eff_addr_i, blk, stride and count = loop_counter_i, and enters ADVANCE at T+1.
  - If loop_counter_i = 0, the request is accepted and dropped; no slot changes.
- ready_and_o is low in any of these cases:
  - flush_i is high;
  - pc_i matches the slot currently driving v_o;
  - replace_p = 0, no IDLE slot exists, and no PC matches.
- ADVANCE, one step per cycle:
  - Compute next = addr + stride modulo 2^vaddr_width_p, and decrement count.
  - If blk(next) ≠ blk, go to SEND with addr = next and blk updated.
  - Otherwise stay in ADVANCE with addr = next; if the new count is 0, go to IDLE instead.
- SEND:
  - The slot requests the output; it holds state until granted and yumi_i.
  - After yumi: go to ADVANCE if count ≠ 0, else IDLE.
- Arbitration:
  - Round-robin among SEND slots, starting after the last yumi'd slot.
  - The grant is locked while v_o is high and yumi_i is low, so pf_vaddr_o and pf_pc_o stay stable until yumi.
  - v_o is registered from slot state, with no combinational path from v_i.
- Latency: accepted at T → earliest v_o at T+2.
- Zero stride never crosses a block. The slot counts down to IDLE and emits nothing.
- flush_i: all slots go to IDLE at the next edge and v_o = 0 the next cycle. A yumi in the flush cycle completes normally. Flush has priority over training in the same cycle.
- Retraining a slot that is in SEND but not granted overwrites it; its pending prefetch is discarded.
- Address wrap past 2^vaddr_width_p − 1 wraps silently.

Test Plan:
- Basic stream: eff = 0x1000, stride = 8, count = 16 → v_o at 0x1040 then 0x1080, pf_pc_o = pc_i; slot IDLE afterwards; exactly 2 requests.
- Negative stride: eff = 0x2000, stride = 0xC0 (−64), count = 3 → requests 0x1FC0, 0x1F80, 0x1F40 in order.
- Zero stride and zero count:
  - stride = 0, count = 5 → no v_o; slot returns to IDLE within 5 cycles.
  - count = 0 → accepted, no state change.
- Two streams (PC A stride 64, PC B stride 128), both in SEND, yumi_i always high → grants alternate A, B, A, B.
- Backpressure: yumi_i held low 10 cycles with v_o high → pf_vaddr_o and pf_pc_o unchanged; a training request with the granted PC sees ready_and_o = 0.
- Full and reset:
  - 5th distinct PC with replace_p = 0 → ready_and_o = 0.
  - Same with replace_p = 1 → slot 0 replaced, then slot 1 on the next miss.
  - Async reset_n_i low mid-SEND → v_o = 0 immediately; all slots IDLE.
